// File: rtl/sum_accum.sv
// Batch accumulator: sums N_SAMPLES 12-bit samples, then holds sum and mean until the
// downstream handshake. Define ACC_SAT_EN to saturate the accumulator and report ovf.
module sum_accum #(
    parameter int N_SAMPLES = 8,
    parameter int ACC_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [11:0]      in_data,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             clear,
    output logic [ACC_W-1:0] out_sum,
    output logic [11:0]      out_avg,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             ovf
);

    localparam int SHIFT = $clog2(N_SAMPLES);
    localparam int CNT_W = SHIFT + 1;

    typedef enum logic [1:0] {
        IDLE,
        ACC,
        HOLD
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ACC_W-1:0]  out_sum_q, out_sum_d;
    logic [11:0]       out_avg_q, out_avg_d;
    logic              out_valid_q, out_valid_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;

    logic              accept;
    logic [ACC_W-1:0]  base;
    logic [ACC_W-1:0]  sum_next;
    logic [ACC_W-1:0]  avg_full;
    logic [CNT_W-1:0]  cnt_next;
    logic              ovf_hit;
`ifdef ACC_SAT_EN
    logic [ACC_W:0]    add_full;
`endif

    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    always_comb begin
        // in_ready_q is already low in HOLD, so this alone rejects input there.
        accept   = in_valid && in_ready_q;
        base     = (state_q == ACC) ? acc_q : '0;
        cnt_next = (state_q == ACC) ? cnt_q + CNT_W'(1) : CNT_W'(1);
`ifdef ACC_SAT_EN
        add_full = {1'b0, base} + (ACC_W + 1)'(in_data);
        ovf_hit  = add_full[ACC_W];
        sum_next = add_full[ACC_W] ? '1 : add_full[ACC_W-1:0];
`else
        ovf_hit  = 1'b0;
        sum_next = base + ACC_W'(in_data);
`endif
        avg_full = sum_next >> SHIFT;

        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_sum_d   = out_sum_q;
        out_avg_d   = out_avg_q;
        out_valid_d = out_valid_q;
        ovf_d       = ovf_q;

        unique case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    acc_d = sum_next;
                    cnt_d = cnt_next;
                    ovf_d = ovf_q | ovf_hit;
                    if (cnt_next == CNT_W'(N_SAMPLES)) begin
                        state_d     = HOLD;
                        out_sum_d   = sum_next;
                        out_avg_d   = (avg_full > ACC_W'(12'hFFF)) ? 12'hFFF : avg_full[11:0];
                        out_valid_d = 1'b1;
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            HOLD: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    acc_d       = '0;
                    cnt_d       = '0;
                    ovf_d       = 1'b0;
                    out_sum_d   = '0;
                    out_avg_d   = '0;
                    out_valid_d = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase

        // Abort wins over any accept or output handshake on the same cycle.
        if (clear) begin
            state_d     = IDLE;
            acc_d       = '0;
            cnt_d       = '0;
            ovf_d       = 1'b0;
            out_sum_d   = '0;
            out_avg_d   = '0;
            out_valid_d = 1'b0;
        end

        in_ready_d = (state_d != HOLD);
    end

    // NOTE: state registers use non-blocking assignments so all of them update together on the edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_sum_q   <= '0;
            out_avg_q   <= '0;
            out_valid_q <= 1'b0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_sum_q   <= out_sum_d;
            out_avg_q   <= out_avg_d;
            out_valid_q <= out_valid_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_sum   = out_sum_q;
    assign out_avg   = out_avg_q;
    assign out_valid = out_valid_q;
    assign ovf       = ovf_q;

endmodule
